// File: rtl/ex_stage.sv
// Execute stage: unpacks the ID/EX control word, runs single-cycle ALU ops or an
// iterative shift-add multiply (stalling upstream), and registers the EX/MEM bundle.
module ex_stage #(
  parameter int XLEN      = 32,
  parameter int MUL_ITERS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [9:0]      control,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [XLEN-1:0] imm,
  input  logic [4:0]      rd,
  input  logic            flush,
  output logic            stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_result,
  output logic [XLEN-1:0] ex_store_data,
  output logic [4:0]      ex_rd,
  output logic            ex_memtoreg,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic            ex_regwrite,
  output logic            ex_branch_taken
);

  localparam int CNT_W = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITERS - 1);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1000;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t            state_q, state_d;
  logic [3:0]        alu_ctl;
  logic [XLEN-1:0]   opb, diff, alu_result;
  logic              zero, is_mul;

  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   mul_a, mul_b, mul_acc, acc_next, mul_store;
  logic [9:0]        mul_ctrl;
  logic [4:0]        mul_rd;
  logic              mul_zero;

  assign alu_ctl  = control[8:5];
  assign opb      = control[4] ? imm : op_b;
  assign diff     = op_a - opb;
  assign zero     = (diff == '0);
  assign is_mul   = in_valid && (alu_ctl == ALU_MUL);
  assign acc_next = mul_acc + (mul_b[0] ? mul_a : '0);

  // NOTE: every variable driven here gets a default first so no path can infer a latch.
  always_comb begin
    alu_result = '0;
    case (alu_ctl)
      ALU_AND: alu_result = op_a & opb;
      ALU_OR:  alu_result = op_a | opb;
      ALU_ADD: alu_result = op_a + opb;
      ALU_XOR: alu_result = op_a ^ opb;
      ALU_SLL: alu_result = op_a << opb[4:0];
      ALU_SRL: alu_result = op_a >> opb[4:0];
      ALU_SUB: alu_result = diff;
      ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(opb))};
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      S_IDLE: if (is_mul) begin
        state_d = S_MUL;
        stall   = 1'b1;
      end
      S_MUL: begin
        stall = (cnt != '0);
        if (cnt == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A flush cancels both the stall request and any pending or running multiply.
    if (flush) begin
      state_d = S_IDLE;
      stall   = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid        <= 1'b0;
      ex_result       <= '0;
      ex_store_data   <= '0;
      ex_rd           <= '0;
      ex_memtoreg     <= 1'b0;
      ex_memread      <= 1'b0;
      ex_memwrite     <= 1'b0;
      ex_regwrite     <= 1'b0;
      ex_branch_taken <= 1'b0;
      cnt             <= '0;
      mul_a           <= '0;
      mul_b           <= '0;
      mul_acc         <= '0;
      mul_store       <= '0;
      mul_ctrl        <= '0;
      mul_rd          <= '0;
      mul_zero        <= 1'b0;
    end else if (flush) begin
      ex_valid        <= 1'b0;
      ex_memtoreg     <= 1'b0;
      ex_memread      <= 1'b0;
      ex_memwrite     <= 1'b0;
      ex_regwrite     <= 1'b0;
      ex_branch_taken <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (is_mul) begin
            mul_a           <= op_a;
            mul_b           <= opb;
            mul_acc         <= '0;
            cnt             <= CNT_LAST;
            mul_rd          <= rd;
            mul_ctrl        <= control;
            mul_store       <= op_b;
            mul_zero        <= zero;
            ex_valid        <= 1'b0;
            ex_memtoreg     <= 1'b0;
            ex_memread      <= 1'b0;
            ex_memwrite     <= 1'b0;
            ex_regwrite     <= 1'b0;
            ex_branch_taken <= 1'b0;
          end else begin
            ex_valid        <= in_valid;
            ex_result       <= alu_result;
            ex_store_data   <= op_b;
            ex_rd           <= rd;
            ex_memtoreg     <= in_valid & control[0];
            ex_memread      <= in_valid & control[3];
            ex_memwrite     <= in_valid & control[2];
            ex_regwrite     <= in_valid & control[9];
            ex_branch_taken <= in_valid & control[1] & zero;
          end
        end
        S_MUL: begin
          mul_acc <= acc_next;
          mul_a   <= mul_a << 1;
          mul_b   <= mul_b >> 1;
          if (cnt != '0) begin
            cnt             <= cnt - 1'b1;
            ex_valid        <= 1'b0;
            ex_memtoreg     <= 1'b0;
            ex_memread      <= 1'b0;
            ex_memwrite     <= 1'b0;
            ex_regwrite     <= 1'b0;
            ex_branch_taken <= 1'b0;
          end else begin
            ex_valid        <= 1'b1;
            ex_result       <= acc_next;
            ex_store_data   <= mul_store;
            ex_rd           <= mul_rd;
            ex_memtoreg     <= mul_ctrl[0];
            ex_memread      <= mul_ctrl[3];
            ex_memwrite     <= mul_ctrl[2];
            ex_regwrite     <= mul_ctrl[9];
            ex_branch_taken <= mul_ctrl[1] & mul_zero;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage: reset, ALU ops, branch compare,
// multi-cycle multiply timing, and flush/reset aborting a multiply.
module tb_ex_stage;

  localparam logic [3:0] AND_ = 4'b0000, OR_ = 4'b0001, ADD = 4'b0010, XOR_ = 4'b0011,
                         SLL = 4'b0100, SRL = 4'b0101, SUB = 4'b0110, SLT = 4'b0111,
                         MUL = 4'b1000;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush;
  logic [9:0]  control;
  logic [31:0] op_a, op_b, imm;
  logic [4:0]  rd;
  logic        stall, ex_valid;
  logic [31:0] ex_result, ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_memtoreg, ex_memread, ex_memwrite, ex_regwrite, ex_branch_taken;

  int n_vec = 0;
  int n_err = 0;

  ex_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .control(control),
    .op_a(op_a), .op_b(op_b), .imm(imm), .rd(rd), .flush(flush),
    .stall(stall), .ex_valid(ex_valid), .ex_result(ex_result),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_memtoreg(ex_memtoreg), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_regwrite(ex_regwrite),
    .ex_branch_taken(ex_branch_taken)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] ctl(input logic rw, input logic [3:0] alu, input logic src,
                                     input logic mr, input logic mw, input logic br,
                                     input logic m2r);
    return {rw, alu, src, mr, mw, br, m2r};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic v, input logic [9:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] i, input logic [4:0] r);
    in_valid = v;
    control  = c;
    op_a     = a;
    op_b     = b;
    imm      = i;
    rd       = r;
  endtask

  // MUL presented after a bubble; ADD 1+2 follows once the stall releases.
  task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    int stalls = 0;
    int pulses = 0;
    present(1'b0, '0, '0, '0, '0, 5'd0);
    tick();
    present(1'b1, ctl(1, MUL, 0, 0, 0, 0, 0), a, b, 32'd0, 5'd9);
    #1;
    while (stall && stalls < 40) begin
      if (ex_valid) pulses++;
      stalls++;
      tick();
    end
    check({tag, "_stall_cycles"}, stalls, 32);
    check({tag, "_valid_during_stall"}, pulses, 0);
    check({tag, "_valid_c32"}, ex_valid, 1'b0);
    tick();
    check({tag, "_valid"}, ex_valid, 1'b1);
    check({tag, "_result"}, ex_result, exp);
    check({tag, "_rd"}, ex_rd, 5'd9);
    check({tag, "_regwrite"}, ex_regwrite, 1'b1);
    present(1'b1, ctl(1, ADD, 0, 0, 0, 0, 0), 32'd1, 32'd2, 32'd0, 5'd4);
    tick();
    check({tag, "_next_add"}, ex_result, 32'd3);
    check({tag, "_next_valid"}, ex_valid, 1'b1);
    check({tag, "_next_rd"}, ex_rd, 5'd4);
  endtask

  typedef struct {
    logic [3:0]  alu;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } alu_vec_t;

  alu_vec_t vecs[9] = '{
    '{AND_,    32'hFFFF_FFF0, 32'h0000_0023, 32'h0000_0020},
    '{OR_,     32'hFFFF_FFF0, 32'h0000_0023, 32'hFFFF_FFF3},
    '{XOR_,    32'hFFFF_FFF0, 32'h0000_0023, 32'hFFFF_FFD3},
    '{SUB,     32'hFFFF_FFF0, 32'h0000_0023, 32'hFFFF_FFCD},
    '{SLL,     32'hFFFF_FFF0, 32'h0000_0023, 32'hFFFF_FF80},
    '{SRL,     32'hFFFF_FFF0, 32'h0000_0023, 32'h1FFF_FFFE},
    '{SLT,     32'hFFFF_FFF0, 32'h0000_0023, 32'h0000_0001},
    '{SLT,     32'h0000_0003, 32'hFFFF_FFF0, 32'h0000_0000},
    '{4'b1001, 32'h0000_0005, 32'h0000_0007, 32'h0000_0000}
  };

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    rst   = 1'b1;
    flush = 1'b0;
    present(1'b1, ctl(1, ADD, 0, 1, 1, 1, 1), 32'd5, 32'd5, 32'd0, 5'd3);
    tick();
    tick();
    check("rst_valid", ex_valid, 1'b0);
    check("rst_result", ex_result, 32'd0);
    check("rst_store", ex_store_data, 32'd0);
    check("rst_rd", ex_rd, 5'd0);
    check("rst_ctrls", {ex_memtoreg, ex_memread, ex_memwrite, ex_regwrite, ex_branch_taken}, 5'd0);
    check("rst_stall", stall, 1'b0);
    rst = 1'b0;

    present(1'b1, ctl(1, ADD, 0, 0, 0, 0, 0), 32'd5, 32'd7, 32'd0, 5'd3);
    tick();
    check("add_reg_result", ex_result, 32'd12);
    check("add_reg_rd", ex_rd, 5'd3);
    check("add_reg_valid", ex_valid, 1'b1);
    check("add_reg_regwrite", ex_regwrite, 1'b1);

    present(1'b1, ctl(1, ADD, 1, 1, 0, 0, 1), 32'd5, 32'd7, 32'hFFFF_FFFF, 5'd3);
    tick();
    check("add_imm_result", ex_result, 32'd4);
    check("add_imm_store", ex_store_data, 32'd7);
    check("add_imm_ctrls", {ex_memtoreg, ex_memread, ex_memwrite}, 3'b110);

    foreach (vecs[k]) begin
      present(1'b1, ctl(1, vecs[k].alu, 0, 0, 0, 0, 0), vecs[k].a, vecs[k].b, 32'd0, 5'd1);
      tick();
      check($sformatf("alu_%0d", k), ex_result, vecs[k].exp);
    end
    check("unknown_op_regwrite", ex_regwrite, 1'b1);

    present(1'b0, ctl(1, SUB, 0, 1, 1, 1, 1), 32'd9, 32'd9, 32'd0, 5'd2);
    tick();
    check("bubble_valid", ex_valid, 1'b0);
    check("bubble_ctrls", {ex_memtoreg, ex_memread, ex_memwrite, ex_regwrite, ex_branch_taken}, 5'd0);

    present(1'b1, ctl(0, SUB, 0, 0, 0, 1, 0), 32'd9, 32'd9, 32'd0, 5'd0);
    tick();
    check("branch_eq", ex_branch_taken, 1'b1);
    present(1'b1, ctl(0, SUB, 0, 0, 0, 1, 0), 32'd9, 32'd8, 32'd0, 5'd0);
    tick();
    check("branch_ne", ex_branch_taken, 1'b0);
    check("branch_ne_result", ex_result, 32'd1);

    do_mul("mul_small", 32'h0001_0003, 32'h0000_0005, 32'h0005_000F);
    do_mul("mul_wrap", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);

    // Flush during iteration 10 of a multiply.
    present(1'b0, '0, '0, '0, '0, 5'd0);
    tick();
    present(1'b1, ctl(1, MUL, 0, 0, 0, 0, 0), 32'd3, 32'd4, 32'd0, 5'd5);
    tick();
    repeat (9) tick();
    check("flush_pre_stall", stall, 1'b1);
    flush    = 1'b1;
    in_valid = 1'b0;
    #1;
    check("flush_stall", stall, 1'b0);
    tick();
    flush = 1'b0;
    #1;
    check("flush_valid", ex_valid, 1'b0);
    check("flush_stall_after", stall, 1'b0);
    pulses = 0;
    repeat (40) begin
      if (ex_valid) pulses++;
      tick();
    end
    check("flush_no_pulse", pulses, 0);
    present(1'b1, ctl(1, ADD, 0, 0, 0, 0, 0), 32'd10, 32'd20, 32'd0, 5'd6);
    tick();
    check("flush_then_add", ex_result, 32'd30);
    check("flush_then_add_valid", ex_valid, 1'b1);

    // Reset during iteration 10 of a multiply; outputs hold a prior ADD beforehand.
    present(1'b1, ctl(1, MUL, 0, 0, 0, 0, 0), 32'd3, 32'd4, 32'd0, 5'd5);
    tick();
    repeat (9) tick();
    rst      = 1'b1;
    in_valid = 1'b0;
    tick();
    check("rstmul_valid", ex_valid, 1'b0);
    check("rstmul_result", ex_result, 32'd0);
    check("rstmul_store", ex_store_data, 32'd0);
    check("rstmul_rd", ex_rd, 5'd0);
    check("rstmul_ctrls", {ex_memtoreg, ex_memread, ex_memwrite, ex_regwrite, ex_branch_taken}, 5'd0);
    check("rstmul_stall", stall, 1'b0);
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      if (ex_valid) pulses++;
      tick();
    end
    check("rstmul_no_pulse", pulses, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
